ins_fetcher: RTL and testbench

Instruction fetch stage feeding the decoder. It requests 32-bit instruction words from the memory controller one at a time and presents each word to the decoder with its PC and a branch prediction. It holds the word until the decoder accepts it. It follows JAL/JALR redirects from the decoder and mispredict flushes from the ROB, and keeps a 2-bit-counter branch history table (BHT) that the ROB trains.

---
 rtl/ins_fetcher_pkg.sv | 14 +
 rtl/fetch_bht.sv | 44 ++++
 rtl/ins_fetcher.sv | 160 ++++++++++++++++
 tb/tb_ins_fetcher.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_fetcher_pkg.sv
// Shared definitions for the instruction fetch stage: RISC-V opcodes that
// the fetcher acts on, and the B-type immediate decode.
package ins_fetcher_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // B-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table: an array of 2-bit saturating counters with one
// combinational read port and one registered training port.
module fetch_bht #(
    parameter int BHT_BITS = 6
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [BHT_BITS-1:0] rd_idx,
    output logic                rd_pred,
    input  logic                wr_valid,
    input  logic [BHT_BITS-1:0] wr_idx,
    input  logic                wr_taken
);
    localparam int ENTRIES = 1 << BHT_BITS;

    logic [1:0] cnt_q [ENTRIES];
    logic [1:0] cnt_d [ENTRIES];

    // Saturating step within 0..3
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        if (up) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
        else    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    endfunction

    // The read port sees the registered value, so a same-cycle update is
    // not visible until the following cycle.
    assign rd_pred = cnt_q[rd_idx][1];

    // Next counter values: only the trained entry moves
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) cnt_d[i] = cnt_q[i];
        if (wr_valid) cnt_d[wr_idx] = sat_step(cnt_q[wr_idx], wr_taken);
    end

    // Counter storage, reset to weakly not-taken
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
        end else begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: rtl/ins_fetcher.sv
// Instruction fetch stage: one outstanding memory request at a time, holds
// each word for the decoder, follows JAL/JALR redirects and ROB flushes, and
// predicts B-type branches from the BHT.
module ins_fetcher
    import ins_fetcher_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          BHT_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic        dec_ins_ready,
    output logic [31:0] dec_ins,
    output logic [31:0] dec_pc,
    output logic        dec_pred_jump,
    input  logic        dec_stall,
    input  logic        dec_clear,
    input  logic [31:0] dec_new_addr,
    input  logic        rob_flush,
    input  logic [31:0] rob_flush_addr,
    input  logic        rob_br_valid,
    input  logic [31:0] rob_br_pc,
    input  logic        rob_br_taken
);
    typedef enum logic [1:0] {ST_FETCH, ST_HOLD, ST_JWAIT, ST_DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        ready_q, ready_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] dpc_q, dpc_d;
    logic        pred_q, pred_d;
    logic        bht_pred;
    logic        unused_ok;

    assign unused_ok = ^{rob_br_pc[31:BHT_BITS+2], rob_br_pc[1:0]};

    fetch_bht #(.BHT_BITS(BHT_BITS)) u_bht (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rd_idx   (pc_q[BHT_BITS+1:2]),
        .rd_pred  (bht_pred),
        .wr_valid (rob_br_valid & rdy_in),
        .wr_idx   (rob_br_pc[BHT_BITS+1:2]),
        .wr_taken (rob_br_taken)
    );

    // Next-state and register updates; everything freezes while rdy_in is low
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ready_d    = ready_q;
        ins_d      = ins_q;
        dpc_d      = dpc_q;
        pred_d     = pred_q;
        if (rdy_in) begin
            if (rob_flush) ready_d = 1'b0;
            case (state_q)
                ST_FETCH: begin
                    if (!mem_req_q) begin
                        // Nothing issued yet: a flush just retargets the pc
                        if (rob_flush) begin
                            pc_d = rob_flush_addr;
                        end else begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = pc_q;
                        end
                    end else if (mem_done) begin
                        mem_req_d = 1'b0;
                        if (rob_flush) begin
                            pc_d = rob_flush_addr;
                        end else begin
                            ins_d   = mem_data;
                            dpc_d   = pc_q;
                            pred_d  = (mem_data[6:0] == OPC_BRANCH) & bht_pred;
                            ready_d = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end else if (rob_flush) begin
                        pc_d    = rob_flush_addr;
                        state_d = ST_DISCARD;
                    end
                end
                ST_HOLD: begin
                    if (rob_flush) begin
                        pc_d    = rob_flush_addr;
                        state_d = ST_FETCH;
                    end else if (!dec_stall) begin
                        ready_d = 1'b0;
                        if (ins_q[6:0] == OPC_JAL || ins_q[6:0] == OPC_JALR) begin
                            state_d = ST_JWAIT;
                        end else begin
                            if (ins_q[6:0] == OPC_BRANCH && pred_q) pc_d = pc_q + imm_b(ins_q);
                            else                                    pc_d = pc_q + 32'd4;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_JWAIT: begin
                    if (rob_flush) begin
                        pc_d    = rob_flush_addr;
                        state_d = ST_FETCH;
                    end else if (dec_clear) begin
                        pc_d    = dec_new_addr;
                        state_d = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    // The old request cannot be aborted; wait it out and drop the data
                    if (rob_flush) pc_d = rob_flush_addr;
                    if (mem_done) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
            ready_q    <= 1'b0;
            ins_q      <= 32'h0;
            dpc_q      <= 32'h0;
            pred_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ready_q    <= ready_d;
            ins_q      <= ins_d;
            dpc_q      <= dpc_d;
            pred_q     <= pred_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign dec_ins_ready = ready_q;
    assign dec_ins       = ins_q;
    assign dec_pc        = dpc_q;
    assign dec_pred_jump = pred_q;

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher with a small memory model answering each
// request three cycles after it is raised.
module tb_ins_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        dec_ins_ready;
    logic [31:0] dec_ins;
    logic [31:0] dec_pc;
    logic        dec_pred_jump;
    logic        dec_stall;
    logic        dec_clear;
    logic [31:0] dec_new_addr;
    logic        rob_flush;
    logic [31:0] rob_flush_addr;
    logic        rob_br_valid;
    logic [31:0] rob_br_pc;
    logic        rob_br_taken;

    int n_total = 0;
    int n_bad   = 0;
    int lat_cnt = 0;

    ins_fetcher #(.RESET_PC(32'h0), .BHT_BITS(6)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_done       (mem_done),
        .mem_data       (mem_data),
        .dec_ins_ready  (dec_ins_ready),
        .dec_ins        (dec_ins),
        .dec_pc         (dec_pc),
        .dec_pred_jump  (dec_pred_jump),
        .dec_stall      (dec_stall),
        .dec_clear      (dec_clear),
        .dec_new_addr   (dec_new_addr),
        .rob_flush      (rob_flush),
        .rob_flush_addr (rob_flush_addr),
        .rob_br_valid   (rob_br_valid),
        .rob_br_pc      (rob_br_pc),
        .rob_br_taken   (rob_br_taken)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0004: return 32'h0010_0093;  // addi x1,x0,1
            32'h0000_0010: return 32'h0000_0463;  // beq x0,x0,+8
            32'h0000_0020: return 32'h0000_006F;  // jal x0,0
            32'h0000_0100: return 32'h0000_0463;  // beq x0,x0,+8
            default:       return 32'h0000_0013;  // nop
        endcase
    endfunction

    // Memory model: mem_done pulses on the third cycle the request is seen
    always @(negedge clk_in) begin
        if (rst_in) begin
            mem_done = 1'b0;
            lat_cnt  = 0;
        end else if (mem_done) begin
            mem_done = 1'b0;
            lat_cnt  = 0;
        end else if (mem_req) begin
            lat_cnt = lat_cnt + 1;
            if (lat_cnt == 3) begin
                mem_done = 1'b1;
                mem_data = mem_word(mem_addr);
            end
        end else begin
            lat_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (mem_req) break;
        end
        chk({tag, "_req"}, {31'b0, mem_req}, 32'd1);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (dec_ins_ready) break;
            tick();
        end
        chk({tag, "_rdy"}, {31'b0, dec_ins_ready}, 32'd1);
    endtask

    task automatic accept(input string tag);
        dec_stall = 1'b0;
        tick();
        dec_stall = 1'b1;
        chk({tag, "_drop"}, {31'b0, dec_ins_ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; dec_stall = 1'b1; dec_clear = 1'b0;
        dec_new_addr = 32'h0; rob_flush = 1'b0; rob_flush_addr = 32'h0;
        rob_br_valid = 1'b0; rob_br_pc = 32'h0; rob_br_taken = 1'b0;
        repeat (2) tick();
        chk("rst_req",  {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_rdy",  {31'b0, dec_ins_ready}, 32'd0);
        chk("rst_ins",  dec_ins, 32'h0);
        chk("rst_pc",   dec_pc, 32'h0);
        chk("rst_pred", {31'b0, dec_pred_jump}, 32'd0);
        rst_in = 1'b0;

        // First fetch from RESET_PC
        wait_req("t1");
        chk("t1_addr", mem_addr, 32'h0);
        wait_ready("t1");
        chk("t1_ins",  dec_ins, 32'h0000_0013);
        chk("t1_pc",   dec_pc, 32'h0);
        chk("t1_pred", {31'b0, dec_pred_jump}, 32'd0);
        accept("t1");
        wait_req("t1n");
        chk("t1_next", mem_addr, 32'h4);

        // Decoder stall holds the word and blocks fetching
        wait_ready("t2");
        chk("t2_ins", dec_ins, 32'h0010_0093);
        chk("t2_pc",  dec_pc, 32'h4);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_ins", dec_ins, 32'h0010_0093);
            chk("t2_hold_pc",  dec_pc, 32'h4);
            chk("t2_hold_req", {31'b0, mem_req}, 32'd0);
            chk("t2_hold_rdy", {31'b0, dec_ins_ready}, 32'd1);
        end
        accept("t2");
        wait_req("t2n");
        chk("t2_next", mem_addr, 32'h8);

        // Flush while the request at 0x8 is outstanding
        rob_flush = 1'b1; rob_flush_addr = 32'h200;
        tick();
        rob_flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!mem_req) break;
            chk("t5_addr_held", mem_addr, 32'h8);
            chk("t5_rdy_low",   {31'b0, dec_ins_ready}, 32'd0);
            tick();
        end
        chk("t5_req_drop", {31'b0, mem_req}, 32'd0);
        chk("t5_rdy_drop", {31'b0, dec_ins_ready}, 32'd0);
        wait_req("t5");
        chk("t5_new_addr", mem_addr, 32'h200);
        chk("t5_rdy_new",  {31'b0, dec_ins_ready}, 32'd0);
        wait_ready("t5");
        chk("t5_pc", dec_pc, 32'h200);

        // Train BHT entry for 0x10 twice (01 -> 11), then flush from HOLD to 0x10
        rob_br_valid = 1'b1; rob_br_pc = 32'h10; rob_br_taken = 1'b1;
        repeat (2) tick();
        rob_br_valid = 1'b0;
        rob_flush = 1'b1; rob_flush_addr = 32'h10;
        tick();
        rob_flush = 1'b0;
        chk("t3_flush_rdy", {31'b0, dec_ins_ready}, 32'd0);
        wait_req("t3");
        chk("t3_addr", mem_addr, 32'h10);
        wait_ready("t3");
        chk("t3_ins",  dec_ins, 32'h0000_0463);
        chk("t3_pred", {31'b0, dec_pred_jump}, 32'd1);
        accept("t3");
        wait_req("t3n");
        chk("t3_target", mem_addr, 32'h18);

        // Walk to the JAL at 0x20
        wait_ready("t4a");
        accept("t4a");
        wait_req("t4b");
        chk("t4_addr1c", mem_addr, 32'h1C);
        wait_ready("t4b");
        accept("t4b");
        wait_req("t4c");
        chk("t4_addr20", mem_addr, 32'h20);
        wait_ready("t4");
        chk("t4_ins",  dec_ins, 32'h0000_006F);
        chk("t4_pred", {31'b0, dec_pred_jump}, 32'd0);
        accept("t4");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_jwait_req", {31'b0, mem_req}, 32'd0);
        end
        dec_clear = 1'b1; dec_new_addr = 32'h100;
        tick();
        dec_clear = 1'b0;
        wait_req("t4n");
        chk("t4_redirect", mem_addr, 32'h100);

        // Untrained branch at 0x100 predicts not taken
        wait_ready("t3u");
        chk("t3u_pc",   dec_pc, 32'h100);
        chk("t3u_pred", {31'b0, dec_pred_jump}, 32'd0);
        accept("t3u");
        wait_req("t3un");
        chk("t3u_next", mem_addr, 32'h104);

        // Flush coincident with acceptance of a predicted-taken branch
        wait_ready("t6a");
        rob_flush = 1'b1; rob_flush_addr = 32'h10;
        tick();
        rob_flush = 1'b0;
        wait_req("t6a");
        chk("t6_addr10", mem_addr, 32'h10);
        wait_ready("t6");
        chk("t6_pred", {31'b0, dec_pred_jump}, 32'd1);
        dec_stall = 1'b0; rob_flush = 1'b1; rob_flush_addr = 32'h300;
        tick();
        dec_stall = 1'b1; rob_flush = 1'b0;
        chk("t6_rdy", {31'b0, dec_ins_ready}, 32'd0);
        wait_req("t6");
        chk("t6_flush_wins", mem_addr, 32'h300);

        // rdy_in low freezes everything, including acceptance and flush
        wait_ready("t7");
        rdy_in = 1'b0; dec_stall = 1'b0; rob_flush = 1'b1; rob_flush_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t7_frz_rdy", {31'b0, dec_ins_ready}, 32'd1);
            chk("t7_frz_pc",  dec_pc, 32'h300);
            chk("t7_frz_req", {31'b0, mem_req}, 32'd0);
        end
        rob_flush = 1'b0; rdy_in = 1'b1;
        tick();
        dec_stall = 1'b1;
        chk("t7_accept", {31'b0, dec_ins_ready}, 32'd0);
        wait_req("t7");
        chk("t7_next", mem_addr, 32'h304);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
